// File: rtl/trap_pkg.sv
// trap_pkg: shared constants and types for the machine-mode trap controller.
// Privilege encodings, exception causes, CSR addresses, mstatus bit indices,
// FSM state enum and the external-interrupt cause offset.
package trap_pkg;

  // Privilege levels
  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_U = 2'b00;

  // Synchronous exception cause codes reported by EX
  localparam logic [3:0] EXC_FETCH_MISALIGN = 4'd0;
  localparam logic [3:0] EXC_ILLEGAL        = 4'd2;
  localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  // mstatus field positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // External interrupt line i reports cause IRQ_CAUSE_OFFSET + i
  localparam int IRQ_CAUSE_OFFSET = 16;

  // Trap sequencer states
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ENTER  = 2'd1,
    ST_RETURN = 2'd2
  } trap_state_e;

  // Only M and U exist; any other MPP encoding collapses to U.
  function automatic logic [1:0] legal_mpp(input logic [1:0] mpp);
    return (mpp == PRIV_M) ? PRIV_M : PRIV_U;
  endfunction

endpackage

// File: rtl/trap_unit_if.sv
// trap_unit_if: pipeline <-> trap controller signal bundle.
// The pipeline side (master) presents exception/retire/mret/CSR requests;
// the trap controller (slave) answers with CSR read data, privilege, and a
// one-cycle flush with redirect target. There is no back-pressure: every
// request is qualified only by its own valid/strobe in the cycle it is
// presented, and flush/redirect_pc are meaningful only while flush=1.
interface trap_unit_if #(
  parameter int XLEN  = 32,
  parameter int N_IRQ = 2
);
  import trap_pkg::*;

  logic              exc_valid;
  logic [3:0]        exc_code;
  logic [XLEN-1:0]   exc_pc;
  logic [XLEN-1:0]   exc_tval;
  logic [N_IRQ-1:0]  irq;
  logic              retire_valid;
  logic [XLEN-1:0]   retire_pc;
  logic              mret_valid;
  logic              csr_we;
  logic              csr_re;
  logic [11:0]       csr_addr;
  logic [XLEN-1:0]   csr_wdata;
  logic [XLEN-1:0]   csr_rdata;
  logic              csr_illegal;
  logic [1:0]        priv;
  logic              flush;
  logic [XLEN-1:0]   redirect_pc;
  trap_state_e       dbg_state;

  modport master (
    output exc_valid, exc_code, exc_pc, exc_tval, irq,
    output retire_valid, retire_pc, mret_valid,
    output csr_we, csr_re, csr_addr, csr_wdata,
    input  csr_rdata, csr_illegal, priv, flush, redirect_pc, dbg_state
  );

  modport slave (
    input  exc_valid, exc_code, exc_pc, exc_tval, irq,
    input  retire_valid, retire_pc, mret_valid,
    input  csr_we, csr_re, csr_addr, csr_wdata,
    output csr_rdata, csr_illegal, priv, flush, redirect_pc, dbg_state
  );

endinterface

// File: rtl/trap_unit_irq_sync.sv
// irq_sync: per-line multi-flop synchroniser for the asynchronous external
// interrupt lines. Level in, level out; no latching of short pulses.
module irq_sync #(
  parameter int N_IRQ  = 2,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_i,
  output logic [N_IRQ-1:0] irq_o
);

  logic [STAGES-1:0][N_IRQ-1:0] sync_q, sync_d;

  // Shift the raw lines one stage deeper each cycle.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], irq_i};
  end

  // Synchroniser flops, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign irq_o = sync_q[STAGES-1];

endmodule

// File: rtl/trap_unit.sv
// trap_unit: machine-mode trap controller for the 5-stage RV32 pipeline.
// Owns the M-mode trap CSRs and M/U privilege, takes EX exceptions, mret and
// synchronised external interrupts, and issues a one-cycle flush/redirect.
// Build option: define TRAP_VECTORED_EN to allow mtvec mode 01 (vectored
// interrupt dispatch); otherwise mtvec[1:0] is hardwired to 00.
module trap_unit
  import trap_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter int              N_IRQ           = 2,
  parameter int              IRQ_SYNC_STAGES = 2,
  parameter logic [XLEN-1:0] MTVEC_RESET     = 32'h0000_0100
) (
  input  logic       clk,
  input  logic       reset,
  trap_unit_if.slave bus
);

  trap_state_e      state_q, state_d;
  logic [1:0]       priv_q, priv_d;
  logic             flush_q, flush_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic             mst_mie_q, mst_mie_d;
  logic             mst_mpie_q, mst_mpie_d;
  logic [1:0]       mst_mpp_q, mst_mpp_d;
  logic [N_IRQ-1:0] mie_q, mie_d;
  logic [XLEN-1:0]  mtvec_q, mtvec_d;
  logic [XLEN-1:0]  mscratch_q, mscratch_d;
  logic [XLEN-1:0]  mepc_q, mepc_d;
  logic [XLEN-1:0]  mcause_q, mcause_d;
  logic [XLEN-1:0]  mtval_q, mtval_d;

  logic [N_IRQ-1:0] mip;
  logic [N_IRQ-1:0] irq_masked;
  logic             irq_hit;
  logic [3:0]       irq_idx;
  logic [4:0]       irq_cause;
  logic             irq_take;
  logic             take_exc;
  logic [3:0]       exc_cause;
  logic             csr_known;
  logic             csr_illegal;
  logic [XLEN-1:0]  csr_rdata;
  logic [XLEN-1:0]  mtvec_base;
  logic [XLEN-1:0]  vec_off;

  irq_sync #(
    .N_IRQ  (N_IRQ),
    .STAGES (IRQ_SYNC_STAGES)
  ) u_irq_sync (
    .clk   (clk),
    .rst_n (reset),
    .irq_i (bus.irq),
    .irq_o (mip)
  );

  // CSR read mux and legality: every implemented CSR is M-only.
  always_comb begin
    csr_known = 1'b1;
    csr_rdata = '0;
    case (bus.csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE]                   = mst_mie_q;
        csr_rdata[MSTATUS_MPIE]                  = mst_mpie_q;
        csr_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mst_mpp_q;
      end
      CSR_MIE:      csr_rdata[N_IRQ-1:0] = mie_q;
      CSR_MTVEC:    csr_rdata            = mtvec_q;
      CSR_MSCRATCH: csr_rdata            = mscratch_q;
      CSR_MEPC:     csr_rdata            = mepc_q;
      CSR_MCAUSE:   csr_rdata            = mcause_q;
      CSR_MTVAL:    csr_rdata            = mtval_q;
      CSR_MIP:      csr_rdata[N_IRQ-1:0] = mip;
      default:      csr_known            = 1'b0;
    endcase
    csr_illegal = (bus.csr_we | bus.csr_re) & (~csr_known | (priv_q != PRIV_M));
  end

  // Pick the lowest-numbered enabled and pending interrupt line.
  always_comb begin
    irq_masked = mie_q & mip;
    irq_hit    = 1'b0;
    irq_idx    = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (irq_masked[i]) begin
        irq_hit = 1'b1;
        irq_idx = 4'(i);
      end
    end
    irq_cause = 5'(IRQ_CAUSE_OFFSET) + {1'b0, irq_idx};
    vec_off   = '0;
    vec_off[6:2] = irq_cause;
  end

  // Event decode: mret from U behaves as an illegal-instruction exception.
  always_comb begin
    take_exc   = bus.exc_valid | (bus.mret_valid & (priv_q != PRIV_M));
    exc_cause  = bus.exc_valid ? bus.exc_code : EXC_ILLEGAL;
    irq_take   = bus.retire_valid & irq_hit & (mst_mie_q | (priv_q == PRIV_U));
    mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};
  end

  // Next-state: trap entry, mret, or an ordinary CSR write when nothing traps.
  always_comb begin
    state_d       = state_q;
    priv_d        = priv_q;
    flush_d       = 1'b0;
    redirect_pc_d = redirect_pc_q;
    mst_mie_d     = mst_mie_q;
    mst_mpie_d    = mst_mpie_q;
    mst_mpp_d     = mst_mpp_q;
    mie_d         = mie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;

    case (state_q)
      ST_RUN: begin
        if (take_exc) begin
          mepc_d          = {bus.exc_pc[XLEN-1:2], 2'b00};
          mcause_d        = '0;
          mcause_d[3:0]   = exc_cause;
          mtval_d         = bus.exc_valid ? bus.exc_tval : '0;
          mst_mpie_d      = mst_mie_q;
          mst_mie_d       = 1'b0;
          mst_mpp_d       = priv_q;
          priv_d          = PRIV_M;
          flush_d         = 1'b1;
          redirect_pc_d   = mtvec_base;
          state_d         = ST_ENTER;
        end else if (bus.mret_valid) begin
          priv_d          = mst_mpp_q;
          mst_mie_d       = mst_mpie_q;
          mst_mpie_d      = 1'b1;
          mst_mpp_d       = PRIV_U;
          flush_d         = 1'b1;
          redirect_pc_d   = mepc_q;
          state_d         = ST_RETURN;
        end else if (irq_take) begin
          mepc_d          = {bus.retire_pc[XLEN-1:2], 2'b00};
          mcause_d        = '0;
          mcause_d[XLEN-1] = 1'b1;
          mcause_d[4:0]   = irq_cause;
          mtval_d         = '0;
          mst_mpie_d      = mst_mie_q;
          mst_mie_d       = 1'b0;
          mst_mpp_d       = priv_q;
          priv_d          = PRIV_M;
          flush_d         = 1'b1;
          redirect_pc_d   = (mtvec_q[1:0] == 2'b01) ? (mtvec_base + vec_off) : mtvec_base;
          state_d         = ST_ENTER;
        end else if (bus.csr_we && !csr_illegal) begin
          case (bus.csr_addr)
            CSR_MSTATUS: begin
              mst_mie_d  = bus.csr_wdata[MSTATUS_MIE];
              mst_mpie_d = bus.csr_wdata[MSTATUS_MPIE];
              mst_mpp_d  = legal_mpp(bus.csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
            end
            CSR_MIE:      mie_d = bus.csr_wdata[N_IRQ-1:0];
`ifdef TRAP_VECTORED_EN
            CSR_MTVEC:    mtvec_d = {bus.csr_wdata[XLEN-1:2],
                                     (bus.csr_wdata[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
            CSR_MTVEC:    mtvec_d = {bus.csr_wdata[XLEN-1:2], 2'b00};
`endif
            CSR_MSCRATCH: mscratch_d = bus.csr_wdata;
            CSR_MEPC:     mepc_d     = {bus.csr_wdata[XLEN-1:2], 2'b00};
            CSR_MCAUSE:   mcause_d   = bus.csr_wdata;
            CSR_MTVAL:    mtval_d    = bus.csr_wdata;
            default:      ;
          endcase
        end
      end
      // The instruction in EX is being squashed: ignore all requests.
      ST_ENTER, ST_RETURN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and CSR registers; reset forces M mode and drops any pending flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      priv_q        <= PRIV_M;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      mst_mie_q     <= 1'b0;
      mst_mpie_q    <= 1'b0;
      mst_mpp_q     <= PRIV_U;
      mie_q         <= '0;
      mtvec_q       <= MTVEC_RESET;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
    end else begin
      state_q       <= state_d;
      priv_q        <= priv_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      mst_mie_q     <= mst_mie_d;
      mst_mpie_q    <= mst_mpie_d;
      mst_mpp_q     <= mst_mpp_d;
      mie_q         <= mie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
    end
  end

  assign bus.csr_rdata   = csr_rdata;
  assign bus.csr_illegal = csr_illegal;
  assign bus.priv        = priv_q;
  assign bus.flush       = flush_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_trap_unit.sv
// tb_trap_unit: directed bench for trap_unit (exceptions, mret, interrupts,
// priority, vectoring, reset mid-trap). Honours TRAP_VECTORED_EN.
module tb_trap_unit;
  import trap_pkg::*;

  localparam int XLEN = 32;
  localparam int N_IRQ = 2;
  localparam int SYNC = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  trap_unit_if #(.XLEN(XLEN), .N_IRQ(N_IRQ)) bus ();

  trap_unit #(
    .XLEN            (XLEN),
    .N_IRQ           (N_IRQ),
    .IRQ_SYNC_STAGES (SYNC),
    .MTVEC_RESET     (32'h0000_0100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] rd_data;
  logic rd_ill;
  logic [XLEN-1:0] exp_v;
  int n;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.exc_valid = 1'b0; bus.exc_code = '0; bus.exc_pc = '0; bus.exc_tval = '0;
    bus.irq = '0; bus.retire_valid = 1'b0; bus.retire_pc = '0; bus.mret_valid = 1'b0;
    bus.csr_we = 1'b0; bus.csr_re = 1'b0; bus.csr_addr = '0; bus.csr_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    tick();
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [XLEN-1:0] d);
    bus.csr_we = 1'b1; bus.csr_addr = a; bus.csr_wdata = d;
    tick();
    bus.csr_we = 1'b0;
  endtask

  task automatic csr_rd(input logic [11:0] a);
    bus.csr_re = 1'b1; bus.csr_addr = a;
    #1;
    rd_data = bus.csr_rdata;
    rd_ill = bus.csr_illegal;
    bus.csr_re = 1'b0;
  endtask

  task automatic wait_flush(input int limit);
    n = 0;
    while (n < limit && bus.flush !== 1'b1) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.priv !== 2'b11) begin bad++; $display("FAIL rst_priv: got %b want 11", bus.priv); end
    total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL rst_flush: got %b want 0", bus.flush); end
    total++; if (bus.redirect_pc !== 32'h0) begin bad++; $display("FAIL rst_redirect: got %h want 0", bus.redirect_pc); end
    total++; if (bus.dbg_state !== ST_RUN) begin bad++; $display("FAIL rst_state: got %0d want %0d", bus.dbg_state, ST_RUN); end
    csr_rd(CSR_MTVEC);
    total++; if (rd_data !== 32'h100) begin bad++; $display("FAIL rst_mtvec: got %h want 100", rd_data); end
    total++; if (rd_ill !== 1'b0) begin bad++; $display("FAIL rst_legal: got %b want 0", rd_ill); end
    csr_rd(CSR_MSTATUS);
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rst_mstatus: got %h want 0", rd_data); end
    csr_rd(CSR_MCAUSE);
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rst_mcause: got %h want 0", rd_data); end
    csr_rd(CSR_MEPC);
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rst_mepc: got %h want 0", rd_data); end
    csr_rd(12'h7C0);
    total++; if (rd_ill !== 1'b1) begin bad++; $display("FAIL unknown_csr_illegal: got %b want 1", rd_ill); end
  endtask

  task automatic test_illegal_exception();
    do_reset();
    csr_wr(CSR_MTVEC, 32'h200);
    bus.exc_valid = 1'b1; bus.exc_code = EXC_ILLEGAL; bus.exc_pc = 32'h40; bus.exc_tval = 32'hDEADBEEF;
    tick();
    bus.exc_valid = 1'b0;
    total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL exc_flush: got %b want 1", bus.flush); end
    total++; if (bus.redirect_pc !== 32'h200) begin bad++; $display("FAIL exc_redirect: got %h want 200", bus.redirect_pc); end
    total++; if (bus.dbg_state !== ST_ENTER) begin bad++; $display("FAIL exc_state: got %0d want %0d", bus.dbg_state, ST_ENTER); end
    csr_rd(CSR_MEPC);
    total++; if (rd_data !== 32'h40) begin bad++; $display("FAIL exc_mepc: got %h want 40", rd_data); end
    csr_rd(CSR_MCAUSE);
    total++; if (rd_data !== 32'h2) begin bad++; $display("FAIL exc_mcause: got %h want 2", rd_data); end
    csr_rd(CSR_MTVAL);
    total++; if (rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL exc_mtval: got %h want deadbeef", rd_data); end
    csr_rd(CSR_MSTATUS);
    total++; if (rd_data !== 32'h1800) begin bad++; $display("FAIL exc_mstatus: got %h want 1800", rd_data); end
    tick();
    total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL exc_flush_pulse: got %b want 0", bus.flush); end
  endtask

  task automatic test_mret_to_u();
    do_reset();
    csr_wr(CSR_MSTATUS, 32'h1080);
    csr_wr(CSR_MEPC, 32'h87);
    csr_rd(CSR_MSTATUS);
    total++; if (rd_data !== 32'h80) begin bad++; $display("FAIL mpp_legalize: got %h want 80", rd_data); end
    csr_rd(CSR_MEPC);
    total++; if (rd_data !== 32'h84) begin bad++; $display("FAIL mepc_align: got %h want 84", rd_data); end
    bus.mret_valid = 1'b1;
    tick();
    bus.mret_valid = 1'b0;
    total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL mret_flush: got %b want 1", bus.flush); end
    total++; if (bus.redirect_pc !== 32'h84) begin bad++; $display("FAIL mret_redirect: got %h want 84", bus.redirect_pc); end
    total++; if (bus.priv !== 2'b00) begin bad++; $display("FAIL mret_priv: got %b want 00", bus.priv); end
    csr_rd(CSR_MSTATUS);
    total++; if (rd_ill !== 1'b1) begin bad++; $display("FAIL u_read_illegal: got %b want 1", rd_ill); end
    tick();
    csr_wr(CSR_MSCRATCH, 32'h55);
    // mret in U is an illegal instruction
    bus.mret_valid = 1'b1; bus.exc_pc = 32'h88;
    tick();
    bus.mret_valid = 1'b0;
    total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL umret_flush: got %b want 1", bus.flush); end
    total++; if (bus.priv !== 2'b11) begin bad++; $display("FAIL umret_priv: got %b want 11", bus.priv); end
    total++; if (bus.redirect_pc !== 32'h100) begin bad++; $display("FAIL umret_redirect: got %h want 100", bus.redirect_pc); end
    csr_rd(CSR_MCAUSE);
    total++; if (rd_data !== 32'h2) begin bad++; $display("FAIL umret_mcause: got %h want 2", rd_data); end
    csr_rd(CSR_MEPC);
    total++; if (rd_data !== 32'h88) begin bad++; $display("FAIL umret_mepc: got %h want 88", rd_data); end
    // MPIE captures MIE=1 set by the earlier mret; MPP records U
    csr_rd(CSR_MSTATUS);
    total++; if (rd_data !== 32'h80) begin bad++; $display("FAIL umret_mstatus: got %h want 80", rd_data); end
    csr_rd(CSR_MSCRATCH);
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL u_write_dropped: got %h want 0", rd_data); end
  endtask

  task automatic test_irq_priority();
    do_reset();
    csr_wr(CSR_MIE, 32'hFFFF_FFFF);
    csr_rd(CSR_MIE);
    total++; if (rd_data !== 32'h3) begin bad++; $display("FAIL mie_mask: got %h want 3", rd_data); end
    csr_wr(CSR_MSTATUS, 32'h8);
    exp_q.push_back(32'h8000_0010);
    exp_q.push_back(32'h8000_0011);
    bus.irq = 2'b11; bus.retire_valid = 1'b1; bus.retire_pc = 32'h100;
    wait_flush(10);
    total++; if (n !== SYNC + 1) begin bad++; $display("FAIL irq_latency: got %0d want %0d", n, SYNC + 1); end
    total++; if (bus.redirect_pc !== 32'h100) begin bad++; $display("FAIL irq0_redirect: got %h want 100", bus.redirect_pc); end
    csr_rd(CSR_MCAUSE);
    exp_v = exp_q.pop_front();
    total++; if (rd_data !== exp_v) begin bad++; $display("FAIL irq0_mcause: got %h want %h", rd_data, exp_v); end
    csr_rd(CSR_MEPC);
    total++; if (rd_data !== 32'h100) begin bad++; $display("FAIL irq0_mepc: got %h want 100", rd_data); end
    csr_rd(CSR_MIP);
    total++; if (rd_data !== 32'h3) begin bad++; $display("FAIL mip_read: got %h want 3", rd_data); end
    bus.irq = 2'b10;
    repeat (SYNC + 1) tick();
    bus.mret_valid = 1'b1;
    tick();
    bus.mret_valid = 1'b0;
    total++; if (bus.redirect_pc !== 32'h100) begin bad++; $display("FAIL irq_mret_redirect: got %h want 100", bus.redirect_pc); end
    tick();
    wait_flush(6);
    total++; if (n !== 1) begin bad++; $display("FAIL irq1_latency: got %0d want 1", n); end
    csr_rd(CSR_MCAUSE);
    exp_v = exp_q.pop_front();
    total++; if (rd_data !== exp_v) begin bad++; $display("FAIL irq1_mcause: got %h want %h", rd_data, exp_v); end
    idle_inputs();
  endtask

  task automatic test_collision();
    do_reset();
    csr_wr(CSR_MIE, 32'h1);
    csr_wr(CSR_MSTATUS, 32'h8);
    bus.irq = 2'b01;
    repeat (SYNC + 1) tick();
    bus.exc_valid = 1'b1; bus.exc_code = EXC_LOAD_MISALIGN; bus.exc_pc = 32'h200; bus.exc_tval = 32'h1234;
    bus.retire_valid = 1'b1; bus.retire_pc = 32'h300;
    bus.csr_we = 1'b1; bus.csr_addr = CSR_MSCRATCH; bus.csr_wdata = 32'hAA;
    tick();
    bus.csr_we = 1'b0; bus.retire_valid = 1'b0;
    bus.exc_code = EXC_STORE_MISALIGN; bus.exc_pc = 32'h500;
    total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL col_flush: got %b want 1", bus.flush); end
    csr_rd(CSR_MCAUSE);
    total++; if (rd_data !== 32'h4) begin bad++; $display("FAIL col_mcause: got %h want 4", rd_data); end
    csr_rd(CSR_MTVAL);
    total++; if (rd_data !== 32'h1234) begin bad++; $display("FAIL col_mtval: got %h want 1234", rd_data); end
    csr_rd(CSR_MSCRATCH);
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL col_csr_dropped: got %h want 0", rd_data); end
    tick();
    bus.exc_valid = 1'b0;
    total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL enter_exc_dropped: got %b want 0", bus.flush); end
    csr_rd(CSR_MEPC);
    total++; if (rd_data !== 32'h200) begin bad++; $display("FAIL enter_mepc_kept: got %h want 200", rd_data); end
    bus.mret_valid = 1'b1;
    tick();
    bus.mret_valid = 1'b0;
    total++; if (bus.redirect_pc !== 32'h200) begin bad++; $display("FAIL col_mret_redirect: got %h want 200", bus.redirect_pc); end
    bus.retire_valid = 1'b1;
    tick();
    wait_flush(6);
    total++; if (n !== 1) begin bad++; $display("FAIL col_irq_after_mret: got %0d want 1", n); end
    csr_rd(CSR_MCAUSE);
    total++; if (rd_data !== 32'h8000_0010) begin bad++; $display("FAIL col_irq_mcause: got %h want 80000010", rd_data); end
    csr_rd(CSR_MEPC);
    total++; if (rd_data !== 32'h300) begin bad++; $display("FAIL col_irq_mepc: got %h want 300", rd_data); end
    csr_rd(CSR_MTVAL);
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL col_irq_mtval: got %h want 0", rd_data); end
    idle_inputs();
  endtask

  task automatic test_vectored();
    logic [XLEN-1:0] exp_mtvec;
    logic [XLEN-1:0] exp_redir;
`ifdef TRAP_VECTORED_EN
    exp_mtvec = 32'h201; exp_redir = 32'h244;
`else
    exp_mtvec = 32'h200; exp_redir = 32'h200;
`endif
    do_reset();
    csr_wr(CSR_MTVEC, 32'h203);
    csr_rd(CSR_MTVEC);
    total++; if (rd_data !== 32'h200) begin bad++; $display("FAIL mtvec_mode_1x: got %h want 200", rd_data); end
    csr_wr(CSR_MTVEC, 32'h201);
    csr_rd(CSR_MTVEC);
    total++; if (rd_data !== exp_mtvec) begin bad++; $display("FAIL mtvec_mode_01: got %h want %h", rd_data, exp_mtvec); end
    csr_wr(CSR_MIE, 32'h2);
    csr_wr(CSR_MSTATUS, 32'h8);
    bus.irq = 2'b10; bus.retire_valid = 1'b1; bus.retire_pc = 32'h60;
    wait_flush(10);
    total++; if (bus.redirect_pc !== exp_redir) begin bad++; $display("FAIL vec_redirect: got %h want %h", bus.redirect_pc, exp_redir); end
    csr_rd(CSR_MCAUSE);
    total++; if (rd_data !== 32'h8000_0011) begin bad++; $display("FAIL vec_mcause: got %h want 80000011", rd_data); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_trap();
    do_reset();
    csr_wr(CSR_MTVEC, 32'h400);
    bus.exc_valid = 1'b1; bus.exc_code = EXC_ILLEGAL; bus.exc_pc = 32'h10;
    tick();
    bus.exc_valid = 1'b0;
    total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL mid_pre_flush: got %b want 1", bus.flush); end
    #2 reset = 1'b0;
    #1;
    total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL mid_flush: got %b want 0", bus.flush); end
    total++; if (bus.priv !== 2'b11) begin bad++; $display("FAIL mid_priv: got %b want 11", bus.priv); end
    total++; if (bus.dbg_state !== ST_RUN) begin bad++; $display("FAIL mid_state: got %0d want %0d", bus.dbg_state, ST_RUN); end
    csr_rd(CSR_MTVEC);
    total++; if (rd_data !== 32'h100) begin bad++; $display("FAIL mid_mtvec: got %h want 100", rd_data); end
    csr_rd(CSR_MCAUSE);
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL mid_mcause: got %h want 0", rd_data); end
    reset = 1'b1;
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_illegal_exception();
    test_mret_to_u();
    test_irq_priority();
    test_collision();
    test_vectored();
    test_reset_mid_trap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/trap_unit.md
Name: trap_unit

Overview:
- Machine-mode trap controller for the 5-stage RV32 pipeline.
- Takes synchronous exceptions from EX and N_IRQ asynchronous external interrupt lines, and owns the M-mode trap CSRs.
- Tracks the M/U privilege level and performs trap entry and mret.
- Drives a one-cycle flush/redirect to fetch; replaces the fixed-priority four-cause mcause mux and the fixed privilege register.

Parameters:
- XLEN, 32: datapath and CSR width.
- N_IRQ, 2: number of external interrupt lines, 1..16. Line i maps to cause 16+i.
- IRQ_SYNC_STAGES, 2: synchroniser depth per irq line, minimum 2.
- MTVEC_RESET, 32'h0000_0100: mtvec reset value.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- exc_valid  in  1  synchronous exception present in EX this cycle.
- exc_code  in  4  RISC-V exception cause: 0 fetch misaligned, 2 illegal, 4 load misaligned, 6 store misaligned.
- exc_pc  in  XLEN  pc of the faulting instruction.
- exc_tval  in  XLEN  faulting address or instruction word.
- irq  in  N_IRQ  level-sensitive external interrupts, asynchronous.
- retire_valid  in  1  EX holds a valid instruction boundary; an interrupt may be taken here.
- retire_pc  in  XLEN  pc to resume at after an interrupt.
- mret_valid  in  1  mret in EX.
- csr_we, csr_re  in  1 each  CSR write / read strobes from EX.
- csr_addr  in  12  CSR address.
- csr_wdata  in  XLEN  write data, already resolved for CSRRW/S/C.
- csr_rdata  out  XLEN  combinational read data.
- csr_illegal  out  1  combinational; unknown address, or any M CSR accessed from U.
- priv  out  2  current privilege: 2'b11 M, 2'b00 U.
- flush  out  1  registered one-cycle pulse; squash IF/ID/EX.
- redirect_pc  out  XLEN  fetch target, valid while flush=1.

Behaviour:
- Reset values: priv=M, flush=0, redirect_pc=0, mstatus=0, mie=0, mepc=0, mcause=0, mtval=0, mscratch=0, mtvec=MTVEC_RESET.
- CSR map:
  - mstatus 0x300: MIE bit 3, MPIE bit 7, MPP bits 12:11; all other bits read 0.
  - mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343.
  - mip 0x344: read-only, returns the synced irq lines; writes ignored.
- Write rules:
  - mepc bits [1:0] are forced to 0.
  - MPP writes other than 00 or 11 are stored as 00.
  - mie bits at or above N_IRQ read 0.
- Illegal CSR access: no state change. EX raises exc_valid with code 2 on the following instruction slot.
- FSM states: RUN, ENTER, RETURN.
- RUN, priority per cycle: exc_valid > mret_valid > pending interrupt.
  - Exception:
    - mepc=exc_pc, mcause={0,exc_code}, mtval=exc_tval.
    - MPIE=MIE, MIE=0, MPP=priv, priv=M.
    - Next state ENTER.
  - mret in M:
    - priv=MPP, MIE=MPIE, MPIE=1, MPP=U.
    - Next state RETURN.
  - mret in U: treated as an exception with code 2, using exc_pc.
  - Interrupt pending when MIE (or priv=U), mie[i], mip[i] and retire_valid are all set.
    - Lowest i wins.
    - mepc=retire_pc, mcause={1,16+i}, mtval=0.
    - Status update as for an exception; next state ENTER.
- ENTER (one cycle):
  - flush=1.
  - redirect_pc = mtvec base, i.e. {mtvec[XLEN-1:2],2'b00}.
  - In vectored mode with an interrupt cause: redirect_pc = base + 4*cause.
  - All inputs ignored this cycle. Next state RUN.
- RETURN (one cycle): flush=1, redirect_pc=mepc (value before any same-cycle write). Next state RUN.
- Latency: event sampled at edge T; flush is high for the cycle following T.
- Simultaneous CSR write and trap in the same cycle: the trap's CSR updates win; the CSR write is dropped.
- An exception arriving during ENTER or RETURN is dropped; its instruction is being squashed.
- irq is level-sensitive with no latching. Deasserting before sync completes loses the request.
- Reset asserted mid-trap returns everything to reset values immediately; flush deasserts asynchronously.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: mtvec[1:0]=01 selects vectored interrupt dispatch. Mode bits are writable with legal values 00 and 01; 1x is stored as 00.
- Undefined: mtvec[1:0] is hardwired 00 and all traps go to base.

Decomposition:
- trap_pkg holds:
  - priv encodings;
  - exception cause codes;
  - CSR address constants;
  - the mstatus bit index constants;
  - the FSM state enum;
  - the interrupt cause offset (16).
- One sub-module, irq_sync: N_IRQ-wide, IRQ_SYNC_STAGES-deep flop chain, asynchronous active-low reset to 0.

Test Plan:
- Illegal exception: reset, mtvec=0x200, then exc_valid code 2, exc_pc=0x40, tval=0xDEADBEEF.
  - Next cycle: flush=1, redirect_pc=0x200.
  - mepc=0x40, mcause=2, mtval=0xDEADBEEF, MIE=0, MPP=11.
- mret to U: write MPP=00, MPIE=1, mepc=0x84, then mret.
  - Next cycle: flush=1, redirect_pc=0x84, priv=00, MIE=1.
  - A subsequent read of 0x300 gives csr_illegal=1 and no state change.
- Interrupt priority: MIE=1, mie=0b11, irq=0b11, retire_valid=1, retire_pc=0x100.
  - Trap taken IRQ_SYNC_STAGES+1 cycles after irq rises.
  - mcause=0x8000_0010, mepc=0x100.
  - After mret, line 1 is taken: mcause=0x8000_0011.
- Priority collision: exc_valid and a pending irq in the same cycle.
  - Exception taken, mcause=exc_code.
  - Interrupt taken after the subsequent mret.
- Vectored mode (TRAP_VECTORED_EN defined): mtvec=0x201, irq[1].
  - redirect_pc=0x200+4*17=0x244.
  - Same test built without the macro: mtvec reads 0x200, redirect_pc=0x200.
- Reset mid-trap: assert reset during ENTER.
  - flush=0 immediately; priv=M; mtvec=MTVEC_RESET; mcause=0.
